// File: rtl/mem_refill_arbiter.sv
// mem_refill_arbiter: round-robin share of the refill memory port with slot-based TID remapping.
// Optional MEM_ARB_PERF_EN adds per-port saturating stall counters on perf_stall_o.
module mem_refill_arbiter #(
   parameter int NR_PORTS        = 2,
   parameter int ADDR_W          = 32,
   parameter int DATA_W          = 128,
   parameter int TID_W           = 2,
   parameter int MAX_OUTSTANDING = 7
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [NR_PORTS-1:0]        port_req_valid_i,
   output logic [NR_PORTS-1:0]        port_req_ready_o,
   input  logic [NR_PORTS*ADDR_W-1:0] port_req_addr_i,
   input  logic [NR_PORTS*TID_W-1:0]  port_req_tid_i,
   output logic [NR_PORTS-1:0]        port_rsp_valid_o,
   output logic [TID_W-1:0]           port_rsp_tid_o,
   output logic [DATA_W-1:0]          port_rsp_data_o,
   output logic                       mem_req_valid_o,
   input  logic                       mem_req_ready_i,
   output logic [ADDR_W-1:0]          mem_req_addr_o,
   output logic [TID_W-1:0]           mem_req_tid_o,
   input  logic                       mem_rsp_valid_i,
   input  logic [TID_W-1:0]           mem_rsp_tid_i,
   input  logic [DATA_W-1:0]          mem_rsp_data_i,
   output logic                       idle_o,
   output logic                       rsp_err_o
`ifdef MEM_ARB_PERF_EN
   ,output logic [NR_PORTS*32-1:0]    perf_stall_o
`endif
);
   localparam int NR_SLOTS = 2**TID_W;
   localparam int CNT_W    = $clog2(MAX_OUTSTANDING+1);
   localparam int PW       = $clog2(NR_PORTS);

   logic [NR_SLOTS-1:0] slot_busy_q, slot_busy_d;
   logic [PW-1:0]       slot_port_q [NR_SLOTS];
   logic [PW-1:0]       slot_port_d [NR_SLOTS];
   logic [TID_W-1:0]    slot_tid_q  [NR_SLOTS];
   logic [TID_W-1:0]    slot_tid_d  [NR_SLOTS];
   logic [CNT_W-1:0]    cnt_q [NR_PORTS];
   logic [CNT_W-1:0]    cnt_d [NR_PORTS];
   logic [PW-1:0]       rr_ptr_q, rr_ptr_d, lock_port_q, lock_port_d;
   logic                lock_q, lock_d, rsp_err_q, rsp_err_d;
   logic [NR_PORTS-1:0] elig;
   logic [PW-1:0]       grant, rsp_port;
   logic [TID_W-1:0]    free_idx;
   logic                accept, rsp_hit;
`ifdef MEM_ARB_PERF_EN
   logic [31:0]         perf_q [NR_PORTS];
   logic [31:0]         perf_d [NR_PORTS];
`endif

   always_comb begin
      elig = '0;
      for (int i = 0; i < NR_PORTS; i++)
         elig[i] = port_req_valid_i[i] && (cnt_q[i] < CNT_W'(MAX_OUTSTANDING));
      grant = lock_q ? lock_port_q : rr_ptr_q;
      // descending scan so the port closest to rr_ptr wins
      if (!lock_q)
         for (int k = NR_PORTS-1; k >= 0; k--)
            if (elig[(int'(rr_ptr_q)+k) % NR_PORTS]) grant = PW'((int'(rr_ptr_q)+k) % NR_PORTS);
      free_idx = '0;
      for (int s = NR_SLOTS-1; s >= 0; s--)
         if (!slot_busy_q[s]) free_idx = TID_W'(s);
      mem_req_valid_o = (lock_q || |elig) && !(&slot_busy_q);
      accept          = mem_req_valid_o && mem_req_ready_i;
      mem_req_addr_o  = mem_req_valid_o ? port_req_addr_i[int'(grant)*ADDR_W +: ADDR_W] : '0;
      mem_req_tid_o   = mem_req_valid_o ? free_idx : '0;
      port_req_ready_o = '0;
      port_req_ready_o[grant] = accept;
      rsp_hit  = mem_rsp_valid_i && slot_busy_q[mem_rsp_tid_i];
      rsp_port = slot_port_q[mem_rsp_tid_i];
      port_rsp_valid_o = '0;
      port_rsp_valid_o[rsp_port] = rsp_hit;
      port_rsp_tid_o  = rsp_hit ? slot_tid_q[mem_rsp_tid_i] : '0;
      port_rsp_data_o = mem_rsp_data_i;
      idle_o    = ~|slot_busy_q;
      rsp_err_o = rsp_err_q;
      rsp_err_d = mem_rsp_valid_i && !slot_busy_q[mem_rsp_tid_i];
      slot_busy_d = slot_busy_q;
      slot_port_d = slot_port_q;
      slot_tid_d  = slot_tid_q;
      if (rsp_hit) slot_busy_d[mem_rsp_tid_i] = 1'b0;
      if (accept) begin
         slot_busy_d[free_idx] = 1'b1;
         slot_port_d[free_idx] = grant;
         slot_tid_d[free_idx]  = port_req_tid_i[int'(grant)*TID_W +: TID_W];
      end
      for (int i = 0; i < NR_PORTS; i++)
         cnt_d[i] = cnt_q[i] + CNT_W'(accept && grant == PW'(i)) - CNT_W'(rsp_hit && rsp_port == PW'(i));
      rr_ptr_d    = accept ? PW'((int'(grant)+1) % NR_PORTS) : rr_ptr_q;
      lock_d      = accept ? 1'b0 : (mem_req_valid_o ? 1'b1 : lock_q);
      lock_port_d = (!accept && mem_req_valid_o) ? grant : lock_port_q;
`ifdef MEM_ARB_PERF_EN
      for (int i = 0; i < NR_PORTS; i++) begin
         perf_d[i] = perf_q[i] + 32'(port_req_valid_i[i] && !port_req_ready_o[i] && perf_q[i] != '1);
         perf_stall_o[i*32 +: 32] = perf_q[i];
      end
`endif
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         slot_busy_q <= '0;
         slot_port_q <= '{default: '0};
         slot_tid_q  <= '{default: '0};
         cnt_q       <= '{default: '0};
         rr_ptr_q    <= '0;
         lock_q      <= 1'b0;
         lock_port_q <= '0;
         rsp_err_q   <= 1'b0;
`ifdef MEM_ARB_PERF_EN
         perf_q      <= '{default: '0};
`endif
      end else begin
         slot_busy_q <= slot_busy_d;
         slot_port_q <= slot_port_d;
         slot_tid_q  <= slot_tid_d;
         cnt_q       <= cnt_d;
         rr_ptr_q    <= rr_ptr_d;
         lock_q      <= lock_d;
         lock_port_q <= lock_port_d;
         rsp_err_q   <= rsp_err_d;
`ifdef MEM_ARB_PERF_EN
         perf_q      <= perf_d;
`endif
      end
   end
endmodule
